// File: rtl/dvfs_pkg.sv
// Shared DVFS types and code constants, used by the transition sequencer and the DPMU policy FSM.
package dvfs_pkg;

    localparam int unsigned DefaultVW = 2;
    localparam int unsigned DefaultFW = 3;

    // Minimum codes are the reset/battery-saving operating point.
    localparam int unsigned V_MIN = 0;
    localparam int unsigned F_MIN = 0;

    typedef enum logic [2:0] {
        StIdle,
        StVStep,
        StVWait,
        StFStep,
        StFWait,
        StDone
    } dvfs_state_e;

endpackage

// File: rtl/dvfs_settle_timer.sv
// Loadable down-counter timing regulator settle and PLL lock waits; one instance serves both phases.
module dvfs_settle_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] value_o,
    output logic             expired_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign value_o   = cnt_q;
    // Expired in the last wait cycle, so a wait of N lasts exactly N cycles.
    assign expired_o = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/dvfs_transition_seq.sv
// Per-domain DVFS sequencer: ramps VID/PLL codes one step at a time, V-before-F up, F-before-V down.
// Optional macro DVFS_SEQ_FASTDOWN_EN: downward frequency phase jumps straight to target in one step.
module dvfs_transition_seq
    import dvfs_pkg::*;
#(
    parameter int unsigned V_W          = DefaultVW,
    parameter int unsigned F_W          = DefaultFW,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned V_SETTLE_CYC = 16,
    parameter int unsigned F_LOCK_CYC   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [V_W-1:0] tgt_v_i,
    input  logic [F_W-1:0] tgt_f_i,
    input  logic           tgt_valid_i,
    output logic           tgt_ready_o,
    output logic [V_W-1:0] vout_o,
    output logic [F_W-1:0] fout_o,
    output logic           busy_o,
    output logic           done_o
);

    dvfs_state_e    state_q, state_d;
    logic [V_W-1:0] vout_q, vout_d, tgt_v_q, tgt_v_d;
    logic [F_W-1:0] fout_q, fout_d, tgt_f_q, tgt_f_d;
    logic           v_first_q, v_first_d;

    logic             tmr_load, tmr_dec, tmr_expired;
    logic [CNT_W-1:0] tmr_load_val, tmr_val;

    dvfs_settle_timer #(
        .CNT_W(CNT_W)
    ) u_settle_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (tmr_load),
        .load_val_i(tmr_load_val),
        .dec_i     (tmr_dec),
        .value_o   (tmr_val),
        .expired_o (tmr_expired)
    );

    always_comb begin
        state_d      = state_q;
        vout_d       = vout_q;
        fout_d       = fout_q;
        tgt_v_d      = tgt_v_q;
        tgt_f_d      = tgt_f_q;
        v_first_d    = v_first_q;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (tgt_valid_i) begin
                    tgt_v_d   = tgt_v_i;
                    tgt_f_d   = tgt_f_i;
                    v_first_d = (tgt_v_i >= vout_q);
                    // Phases already at target are skipped outright.
                    if (tgt_v_i > vout_q) begin
                        state_d = StVStep;
                    end else if (tgt_f_i != fout_q) begin
                        state_d = StFStep;
                    end else if (tgt_v_i != vout_q) begin
                        state_d = StVStep;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StVStep: begin
                vout_d       = (tgt_v_q > vout_q) ? vout_q + 1'b1 : vout_q - 1'b1;
                tmr_load     = 1'b1;
                tmr_load_val = CNT_W'(V_SETTLE_CYC);
                state_d      = StVWait;
            end
            StVWait: begin
                tmr_dec = (tmr_val != '0);
                if (tmr_expired) begin
                    if (vout_q != tgt_v_q) begin
                        state_d = StVStep;
                    end else if (v_first_q && (fout_q != tgt_f_q)) begin
                        state_d = StFStep;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StFStep: begin
`ifdef DVFS_SEQ_FASTDOWN_EN
                fout_d = (tgt_f_q < fout_q) ? tgt_f_q : fout_q + 1'b1;
`else
                fout_d = (tgt_f_q > fout_q) ? fout_q + 1'b1 : fout_q - 1'b1;
`endif
                tmr_load     = 1'b1;
                tmr_load_val = CNT_W'(F_LOCK_CYC);
                state_d      = StFWait;
            end
            StFWait: begin
                tmr_dec = (tmr_val != '0);
                if (tmr_expired) begin
                    if (fout_q != tgt_f_q) begin
                        state_d = StFStep;
                    end else if (!v_first_q && (vout_q != tgt_v_q)) begin
                        state_d = StVStep;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            vout_q    <= V_W'(V_MIN);
            fout_q    <= F_W'(F_MIN);
            tgt_v_q   <= V_W'(V_MIN);
            tgt_f_q   <= F_W'(F_MIN);
            v_first_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vout_q    <= vout_d;
            fout_q    <= fout_d;
            tgt_v_q   <= tgt_v_d;
            tgt_f_q   <= tgt_f_d;
            v_first_q <= v_first_d;
        end
    end

    assign tgt_ready_o = (state_q == StIdle);
    assign busy_o      = (state_q != StIdle);
    assign done_o      = (state_q == StDone);
    assign vout_o      = vout_q;
    assign fout_o      = fout_q;

endmodule

// File: tb/tb_dvfs_transition_seq.sv
// Randomized bench for dvfs_transition_seq against a cycle-timeline reference model.
module tb_dvfs_transition_seq;

    localparam int unsigned VS = 4;
    localparam int unsigned FL = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] tgt_v = '0;
    logic [2:0] tgt_f = '0;
    logic       tgt_valid = 1'b0;
    logic       tgt_ready, busy, done;
    logic [1:0] vout;
    logic [2:0] fout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    // Expected per-cycle view {busy, done, ready, vout, fout}, cycle 1 first.
    logic [7:0] exp_q[$];
    int         e_v, e_f, e_tv, e_tf;
    int         m_v = 0, m_f = 0;

    dvfs_transition_seq #(
        .V_W         (2),
        .F_W         (3),
        .CNT_W       (8),
        .V_SETTLE_CYC(VS),
        .F_LOCK_CYC  (FL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tgt_v_i    (tgt_v),
        .tgt_f_i    (tgt_f),
        .tgt_valid_i(tgt_valid),
        .tgt_ready_o(tgt_ready),
        .vout_o     (vout),
        .fout_o     (fout),
        .busy_o     (busy),
        .done_o     (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs();
        return {busy, done, tgt_ready, vout, fout};
    endfunction

    function automatic logic [7:0] pack(input int b, input int d, input int r, input int v,
                                        input int f);
        logic [7:0] p;
        p = {b[0], d[0], r[0], v[1:0], f[2:0]};
        return p;
    endfunction

    task automatic chk(input string tag, input int unsigned got, input int unsigned expv);
        n_checks++;
        if (got == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    endtask

    // Each step: one cycle at old code, then the wait cycles at the new code.
    task automatic v_phase();
        while (e_v != e_tv) begin
            exp_q.push_back(pack(1, 0, 0, e_v, e_f));
            e_v = (e_v < e_tv) ? e_v + 1 : e_v - 1;
            repeat (VS) exp_q.push_back(pack(1, 0, 0, e_v, e_f));
        end
    endtask

    task automatic f_phase();
        while (e_f != e_tf) begin
            exp_q.push_back(pack(1, 0, 0, e_v, e_f));
`ifdef DVFS_SEQ_FASTDOWN_EN
            e_f = (e_f < e_tf) ? e_f + 1 : e_tf;
`else
            e_f = (e_f < e_tf) ? e_f + 1 : e_f - 1;
`endif
            repeat (FL) exp_q.push_back(pack(1, 0, 0, e_v, e_f));
        end
    endtask

    task automatic build_model(input int tv, input int tf);
        exp_q.delete();
        e_v = m_v; e_f = m_f; e_tv = tv; e_tf = tf;
        if (tv >= m_v) begin
            v_phase(); f_phase();
        end else begin
            f_phase(); v_phase();
        end
        exp_q.push_back(pack(1, 1, 0, e_v, e_f));
        exp_q.push_back(pack(0, 0, 1, e_v, e_f));
        m_v = tv; m_f = tf;
    endtask

    // Called in an idle cycle, #1 after a clock edge.
    task automatic run_txn(input int tv, input int tf, input bit pulse, input bit b2b,
                           input int nv, input int nf, input int reset_at, input int lit_done);
        int d_exp, d_obs, pulse_at;
        build_model(tv, tf);
        d_exp    = exp_q.size() - 1;
        pulse_at = (pulse && d_exp >= 3) ? 2 : 0;
        chk("ready_pre", tgt_ready, 1);
        tgt_valid = 1'b1;
        tgt_v = 2'(tv);
        tgt_f = 3'(tf);
        @(posedge clk); #1;
        tgt_valid = 1'b0;
        d_obs = 0;
        for (int k = 1; k <= d_exp + 1; k++) begin
            chk($sformatf("t%0d/%0d cyc%0d", tv, tf, k), obs(), exp_q[k-1]);
            if (done && d_obs == 0) d_obs = k;
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk("rst_async", obs(), 8'h20);
                #3;
                rst_n = 1'b1;
                @(posedge clk); #1;
                chk("rst_after", obs(), 8'h20);
                m_v = 0; m_f = 0;
                return;
            end
            if (k == pulse_at) begin
                tgt_valid = 1'b1; tgt_v = 2'd3; tgt_f = 3'd7;
            end else if (b2b && k == d_exp) begin
                tgt_valid = 1'b1; tgt_v = 2'(nv); tgt_f = 3'(nf);
            end else begin
                tgt_valid = 1'b0;
            end
            if (k <= d_exp) begin
                @(posedge clk); #1;
            end
        end
        chk("done_cyc", d_obs, d_exp);
        if (lit_done > 0) chk("done_lit", d_obs, lit_done);
    endtask

    initial begin
        int nv, nf, cv, cf;
        bit b2b;
        #12;
        chk("rst_vout", vout, 0);
        chk("rst_fout", fout, 0);
        chk("rst_ready", tgt_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 2, 0, 0, 0, 0, 0, 0);
        run_txn(2, 3, 0, 0, 0, 0, 0, 9);    // up: done in cycle 9
        run_txn(3, 7, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 0, 0);    // down: F first, then V
        run_txn(1, 2, 0, 0, 0, 0, 0, 0);
        run_txn(1, 2, 0, 0, 0, 0, 0, 1);    // same target
        run_txn(2, 4, 1, 0, 0, 0, 0, 0);    // pulse 11/111 while busy
        run_txn(0, 1, 0, 1, 3, 6, 0, 0);    // back-to-back hold
        run_txn(3, 6, 0, 0, 0, 0, 0, 0);

        cv = $urandom_range(3);
        cf = $urandom_range(7);
        for (int i = 0; i < 40; i++) begin
            nv  = $urandom_range(3);
            nf  = $urandom_range(7);
            b2b = ($urandom_range(3) == 0);
            run_txn(cv, cf, ($urandom_range(3) == 0), b2b, nv, nf, 0, 0);
            if (b2b) begin
                cv = nv; cf = nf;
            end else begin
                cv = $urandom_range(3); cf = $urandom_range(7);
            end
        end

        run_txn(3, 7, 0, 0, 0, 0, 0, 0);
        run_txn(0, 0, 0, 0, 0, 0, 3, 0);    // reset mid-ramp
        run_txn(2, 5, 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
